// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if: requester, arbiter and serial-master signals of one shared bus
interface serial_bus_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int BUS_BITS = 8
);
    logic [NUM_REQ-1:0]          in_req_enable;
    logic [NUM_REQ*BUS_BITS-1:0] in_req_data;
    logic [NUM_REQ-1:0]          out_req_ready;
    logic [NUM_REQ-1:0]          out_req_next_word;
    logic [NUM_REQ-1:0]          out_grant;
    logic                        out_bus_enable;
    logic [BUS_BITS-1:0]         out_bus_data;
    logic                        in_bus_ready;
    logic                        in_bus_next_word;
    logic                        out_timeout;
    modport slave (
        input  in_req_enable, in_req_data, in_bus_ready, in_bus_next_word,
        output out_req_ready, out_req_next_word, out_grant, out_bus_enable, out_bus_data, out_timeout
    );
    modport master (
        output in_req_enable, in_req_data, in_bus_ready, in_bus_next_word,
        input  out_req_ready, out_req_next_word, out_grant, out_bus_enable, out_bus_data, out_timeout
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin sharing of one serial master with per-grant hold timeout
module serial_bus_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUS_BITS     = 8,
    parameter int HOLD_TIMEOUT = 2_700_000
) (
    input logic                in_clk,
    input logic                in_rst,
    serial_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       idx_q, idx_d, last_q, last_d, pick;
    logic [CW-1:0]       hold_q, hold_d;
    logic                timeout_q, timeout_d;
    logic                act;
    always_comb begin
        pick = last_q;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.in_req_enable[(int'(last_q) + k) % NUM_REQ]) pick = IW'((int'(last_q) + k) % NUM_REQ);
    end
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (bus.in_bus_ready && |bus.in_req_enable) begin
                state_d = GRANT;
                grant_d = NUM_REQ'(1) << pick;
                idx_d   = pick;
                hold_d  = '0;
            end
            GRANT: begin
                hold_d = hold_q + 1'b1;
                if (!bus.in_req_enable[idx_q]) state_d = RELEASE;
                else if (hold_q == CW'(HOLD_TIMEOUT - 1)) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: if (bus.in_bus_ready) begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = idx_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign act                   = state_q == GRANT && !in_rst;
    assign bus.out_grant         = grant_q;
    assign bus.out_timeout       = timeout_q;
    assign bus.out_bus_enable    = act && bus.in_req_enable[idx_q];
    assign bus.out_bus_data      = act ? bus.in_req_data[idx_q*BUS_BITS +: BUS_BITS] : '0;
    assign bus.out_req_ready     = act ? grant_q & {NUM_REQ{bus.in_bus_ready}} : '0;
    assign bus.out_req_next_word = act ? grant_q & {NUM_REQ{bus.in_bus_next_word}} : '0;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed checks of arbitration, routing, release and timeout
module tb_serial_bus_arbiter;
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    serial_bus_arbiter_if #(.NUM_REQ(2), .BUS_BITS(8)) bus ();
    serial_bus_arbiter #(.NUM_REQ(2), .BUS_BITS(8), .HOLD_TIMEOUT(16)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .bus(bus)
    );
    always #5 in_clk = ~in_clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        step(2);
        in_rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_req_enable = 2'b00; bus.in_req_data = 16'h0000;
        bus.in_bus_ready = 1'b1; bus.in_bus_next_word = 1'b0;
        do_reset();
        n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant got %b want 00", bus.out_grant); end
        n_cmp++; if (bus.out_bus_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable got %b want 0", bus.out_bus_enable); end
        n_cmp++; if (bus.out_bus_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", bus.out_bus_data); end
        n_cmp++; if (bus.out_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", bus.out_timeout); end
    endtask

    task automatic test_single();
        bus.in_req_enable = 2'b01; bus.in_req_data = 16'h003C;
        step();
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL single_grant got %b want 01", bus.out_grant); end
        n_cmp++; if (bus.out_bus_enable !== 1'b1) begin n_bad++; $display("FAIL single_enable got %b want 1", bus.out_bus_enable); end
        n_cmp++; if (bus.out_bus_data !== 8'h3C) begin n_bad++; $display("FAIL single_data got %h want 3c", bus.out_bus_data); end
        n_cmp++; if (bus.out_req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b want 01", bus.out_req_ready); end
        bus.in_bus_next_word = 1'b1; #1;
        n_cmp++; if (bus.out_req_next_word !== 2'b01) begin n_bad++; $display("FAIL single_next got %b want 01", bus.out_req_next_word); end
        bus.in_bus_next_word = 1'b0;
        bus.in_req_enable = 2'b00;
        step();
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL single_release_grant got %b want 01", bus.out_grant); end
        n_cmp++; if (bus.out_bus_enable !== 1'b0) begin n_bad++; $display("FAIL single_release_enable got %b want 0", bus.out_bus_enable); end
        step();
        n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL single_idle_grant got %b want 00", bus.out_grant); end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        int g;
        do_reset();
        bus.in_req_enable = 2'b11;
        step();
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL contention_first got %b want 01", bus.out_grant); end
        g = 0;
        for (int r = 0; r < 3; r++) begin
            bus.in_req_enable = (g == 0) ? 2'b10 : 2'b01;
            step();
            bus.in_req_enable = 2'b11;
            step();
            n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL contention_gap%0d got %b want 00", r, bus.out_grant); end
            step();
            g = 1 - g;
            exp = (g == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (bus.out_grant !== exp) begin n_bad++; $display("FAIL contention_round%0d got %b want %b", r, bus.out_grant, exp); end
        end
    endtask

    task automatic test_routing();
        bus.in_req_data = 16'hA55A;
        bus.in_bus_next_word = 1'b1; #1;
        n_cmp++; if (bus.out_req_next_word !== 2'b10) begin n_bad++; $display("FAIL route_next got %b want 10", bus.out_req_next_word); end
        n_cmp++; if (bus.out_req_ready !== 2'b10) begin n_bad++; $display("FAIL route_ready got %b want 10", bus.out_req_ready); end
        n_cmp++; if (bus.out_bus_data !== 8'hA5) begin n_bad++; $display("FAIL route_data got %h want a5", bus.out_bus_data); end
        bus.in_req_data = 16'hA5FF; #1;
        n_cmp++; if (bus.out_bus_data !== 8'hA5) begin n_bad++; $display("FAIL route_data0_ignored got %h want a5", bus.out_bus_data); end
        bus.in_bus_next_word = 1'b0;
        bus.in_req_enable = 2'b01;
        step();
        bus.in_req_enable = 2'b11;
        step(2);
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL route_handover got %b want 01", bus.out_grant); end
    endtask

    task automatic test_reset_mid_grant();
        in_rst = 1'b1;
        step();
        n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL midrst_grant got %b want 00", bus.out_grant); end
        n_cmp++; if (bus.out_bus_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_enable got %b want 0", bus.out_bus_enable); end
        n_cmp++; if (bus.out_req_ready !== 2'b00) begin n_bad++; $display("FAIL midrst_ready got %b want 00", bus.out_req_ready); end
        n_cmp++; if (bus.out_bus_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got %h want 00", bus.out_bus_data); end
        in_rst = 1'b0;
        step();
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL midrst_priority got %b want 01", bus.out_grant); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.in_req_enable = 2'b01;
        step(16);
        n_cmp++; if (bus.out_bus_enable !== 1'b1) begin n_bad++; $display("FAIL timeout_last_cycle_enable got %b want 1", bus.out_bus_enable); end
        n_cmp++; if (bus.out_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early got %b want 0", bus.out_timeout); end
        step();
        n_cmp++; if (bus.out_bus_enable !== 1'b0) begin n_bad++; $display("FAIL timeout_enable got %b want 0", bus.out_bus_enable); end
        n_cmp++; if (bus.out_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag got %b want 1", bus.out_timeout); end
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL timeout_release_grant got %b want 01", bus.out_grant); end
        bus.in_req_enable = 2'b11;
        step(2);
        n_cmp++; if (bus.out_grant !== 2'b10) begin n_bad++; $display("FAIL timeout_next_grant got %b want 10", bus.out_grant); end
        n_cmp++; if (bus.out_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got %b want 1", bus.out_timeout); end
    endtask

    task automatic test_busy_release();
        bus.in_req_enable = 2'b01;
        bus.in_bus_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.out_grant !== 2'b10) begin n_bad++; $display("FAIL busy_hold%0d got %b want 10", i, bus.out_grant); end
        end
        n_cmp++; if (bus.out_bus_enable !== 1'b0) begin n_bad++; $display("FAIL busy_enable got %b want 0", bus.out_bus_enable); end
        bus.in_bus_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL busy_idle got %b want 00", bus.out_grant); end
        step();
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL busy_next got %b want 01", bus.out_grant); end
    endtask

    task automatic test_drop_at_timeout();
        do_reset();
        bus.in_req_enable = 2'b01;
        step(16);
        bus.in_req_enable = 2'b00;
        step();
        n_cmp++; if (bus.out_timeout !== 1'b0) begin n_bad++; $display("FAIL drop_timeout_flag got %b want 0", bus.out_timeout); end
        n_cmp++; if (bus.out_grant !== 2'b01) begin n_bad++; $display("FAIL drop_timeout_grant got %b want 01", bus.out_grant); end
        step();
        n_cmp++; if (bus.out_grant !== 2'b00) begin n_bad++; $display("FAIL drop_timeout_idle got %b want 00", bus.out_grant); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_routing();
        test_reset_mid_grant();
        test_timeout();
        test_busy_release();
        test_drop_at_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
